croc_pad_ctrl: RTL
==================

# croc_pad_ctrl

Parametrised GPIO pad controller between `croc_soc` and the `sg13g2_IOPadInOut30mA` pad ring. It replaces the direct per-pad wiring of SoC GPIO nets, and is generalised to `NumPads` channels. Each channel adds:
- a registered output/enable path;
- an input synchroniser and per-channel programmable glitch filter;
- edge detection;
- a sticky, maskable interrupt;
- a test-mode safe state that forces every pad to input.

## Interface
Parameters:
- `NumPads`, 32, number of GPIO channels (1..32).
- `SyncStages`, 2, input synchroniser depth (>= 2).
- `FilterW`, 4, width of the filter length and counter.

Ports:
- `clk_i`  in  1  system clock; all state on its rising edge.
- `rst_ni`  in  1  asynchronous active-low reset.
- `testmode_i`  in  1  1 = force pads to input, outputs low.
- `soc_gpio_o_i`  in  NumPads  output data from SoC.
- `soc_gpio_oe_i`  in  NumPads  output enable from SoC (1 = drive).
- `soc_gpio_i_o`  out  NumPads  synchronised, filtered input to SoC.
- `pad_c2p_o`  out  NumPads  to pad `c2p`.
- `pad_c2p_en_o`  out  NumPads  to pad `c2p_en`.
- `pad_p2c_i`  in  NumPads  from pad `p2c`; asynchronous.
- `filt_en_i`  in  NumPads  per-channel filter enable.
- `filt_len_i`  in  FilterW  required stable cycles; 0 is treated as 1.
- `rise_o`  out  NumPads  one-cycle pulse on a filtered 0->1 transition.
- `fall_o`  out  NumPads  one-cycle pulse on a filtered 1->0 transition.
- `irq_mask_i`  in  NumPads  1 = channel masked from `irq_o`.
- `irq_clr_i`  in  NumPads  clear pending bit; level, sampled each cycle.
- `irq_pend_o`  out  NumPads  sticky edge-pending bits.
- `irq_o`  out  1  OR of `irq_pend_o & ~irq_mask_i`.

## Operation
Output path, per channel:
- `pad_c2p_o` <= `soc_gpio_o_i & ~testmode_i`.
- `pad_c2p_en_o` <= `soc_gpio_oe_i & ~testmode_i`.
- Both are registered (flop); no combinational path from SoC to pad.

Input path, per channel:
- `pad_p2c_i` passes through a `SyncStages`-flop chain, giving `sync`.
- The filter holds the filtered value `filt` (driven on `soc_gpio_i_o`) and a counter `cnt` of width `FilterW`. Let L = max(`filt_len_i`, 1), or 1 when `filt_en_i` = 0.
- If `sync` == `filt`: `cnt` <= 0.
- If `sync` != `filt` and `cnt` >= L-1: `filt` <= `sync`, `cnt` <= 0.
- Otherwise: `cnt` <= `cnt`+1, saturating at all-ones.
- The comparison is >= so that lowering `filt_len_i` mid-count commits on the next mismatching cycle. Raising it extends the wait.
- A pulse shorter than L cycles at `sync` never reaches `filt` and produces no edge.

Edges and interrupt:
- `rise_o` / `fall_o` are registered and high for exactly the first cycle in which `soc_gpio_i_o` shows the new value.
- `irq_pend_o[i]` is set by `rise_o[i] | fall_o[i]` and cleared by `irq_clr_i[i]`. Set wins over a simultaneous clear, so no event is lost.
- `irq_o` is combinational from `irq_pend_o` and `irq_mask_i`. Masking does not stop pend bits from setting.

Test mode:
- Affects only the output path; the input path keeps running.
- Assert/deassert takes effect on pads one cycle later.

## Timing
- Reset values, with the async clear reaching every flop:
  - `pad_c2p_o` = 0, `pad_c2p_en_o` = 0 (all pads are inputs);
  - sync chain = 0, `filt` = 0, `cnt` = 0;
  - `rise_o` = `fall_o` = 0, `irq_pend_o` = 0, `irq_o` = 0.
- Output latency: 1 cycle from `soc_gpio_*_i` to pad.
- Input latency from a pad change to `soc_gpio_i_o`:
  - filter off: SyncStages+1 cycles;
  - filter on: SyncStages+L cycles, with the input held stable throughout.
- `rise_o` / `fall_o` appear in the same cycle as the `soc_gpio_i_o` change. `irq_pend_o` sets 1 cycle later.
- A pad held high through reset release produces one `rise_o` after the input latency. This is expected behaviour.
- Reset asserted mid-filter: `cnt` and `filt` clear immediately and no edge pulse is produced.

## Test plan
- Reset with all pads high, `filt_en_i` = 0, SyncStages = 2: after release, `soc_gpio_i_o` = all-ones on cycle 3, `rise_o` = all-ones for exactly one cycle, `irq_pend_o` = all-ones on cycle 4, `irq_o` = 1 with mask 0.
- Channel 0, filter on, `filt_len_i` = 5:
  - a 4-cycle high glitch gives no change and no `rise_o`;
  - a 5-cycle stable high makes `soc_gpio_i_o[0]` go 1 exactly 2+5 cycles after the pad edge.
- Channel 3: `irq_clr_i[3]` and `rise_o[3]` asserted in the same cycle -> `irq_pend_o[3]` = 1.
  - Then `irq_mask_i[3]` = 1 -> `irq_o` = 0 while `irq_pend_o[3]` stays 1.
  - Then clear -> `irq_pend_o[3]` = 0.
- `soc_gpio_oe_i` = 0xFFFF_FFFF, `soc_gpio_o_i` = 0xA5A5_A5A5:
  - pads show 0xA5A5_A5A5, enable all-ones, one cycle later;
  - `testmode_i` = 1 -> both read 0 the next cycle; deassert restores both the next cycle.
- Filter on, `filt_len_i` = 15, input mismatching for 8 cycles, then `filt_len_i` changed to 3 -> commit on the next cycle. Also assert `rst_ni` mid-count -> `soc_gpio_i_o` = 0, `cnt` = 0, no `fall_o`.

Source files
------------

// File: rtl/croc_pad_ctrl.sv
// croc_pad_ctrl: GPIO pad controller between the SoC and the pad ring.
// Each channel has a registered output/enable path with a test-mode safe
// state, plus an input path made of a synchroniser, a programmable glitch
// filter, edge detection and a sticky, maskable interrupt.
// There is no FSM and no handshake here. Every channel updates on each
// rising clk_i edge.
module croc_pad_ctrl #(
  parameter int NumPads    = 32,
  parameter int SyncStages = 2,
  parameter int FilterW    = 4
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               testmode_i,
  input  logic [NumPads-1:0] soc_gpio_o_i,
  input  logic [NumPads-1:0] soc_gpio_oe_i,
  output logic [NumPads-1:0] soc_gpio_i_o,
  output logic [NumPads-1:0] pad_c2p_o,
  output logic [NumPads-1:0] pad_c2p_en_o,
  input  logic [NumPads-1:0] pad_p2c_i,
  input  logic [NumPads-1:0] filt_en_i,
  input  logic [FilterW-1:0] filt_len_i,
  output logic [NumPads-1:0] rise_o,
  output logic [NumPads-1:0] fall_o,
  input  logic [NumPads-1:0] irq_mask_i,
  input  logic [NumPads-1:0] irq_clr_i,
  output logic [NumPads-1:0] irq_pend_o,
  output logic               irq_o
);

  logic [NumPads-1:0] pad_c2p_d,    pad_c2p_q;
  logic [NumPads-1:0] pad_c2p_en_d, pad_c2p_en_q;
  logic [NumPads-1:0] sync_d [SyncStages];
  logic [NumPads-1:0] sync_q [SyncStages];
  logic [NumPads-1:0] filt_d, filt_q;
  logic [FilterW-1:0] cnt_d [NumPads];
  logic [FilterW-1:0] cnt_q [NumPads];
  logic [NumPads-1:0] rise_d, rise_q;
  logic [NumPads-1:0] fall_d, fall_q;
  logic [NumPads-1:0] irq_pend_d, irq_pend_q;
  logic [FilterW-1:0] len_eff;
  logic [NumPads-1:0] sync_out;

  assign sync_out = sync_q[SyncStages-1];

  // Output path: test mode forces every pad to a non-driving input.
  always_comb begin
    pad_c2p_d    = soc_gpio_o_i  & ~{NumPads{testmode_i}};
    pad_c2p_en_d = soc_gpio_oe_i & ~{NumPads{testmode_i}};
  end

  // Synchroniser chain: stage 0 samples the asynchronous pad input.
  always_comb begin
    sync_d[0] = pad_p2c_i;
    for (int s = 1; s < SyncStages; s++) begin
      sync_d[s] = sync_q[s-1];
    end
  end

  // Glitch filter: commit the synchronised value once it has mismatched the
  // filtered value for L consecutive cycles. The >= comparison lets a
  // lowered length commit immediately on the next mismatching cycle.
  always_comb begin
    len_eff = '1;
    filt_d  = filt_q;
    for (int i = 0; i < NumPads; i++) begin
      cnt_d[i] = cnt_q[i];
      len_eff  = (filt_en_i[i] && (filt_len_i != '0)) ? filt_len_i : FilterW'(1);
      if (sync_out[i] == filt_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] >= (len_eff - FilterW'(1))) begin
        filt_d[i] = sync_out[i];
        cnt_d[i]  = '0;
      end else if (cnt_q[i] != '1) begin
        cnt_d[i] = cnt_q[i] + FilterW'(1);
      end
    end
  end

  // Edge pulses line up with the cycle the filtered value first changes;
  // pending bits give priority to a new event over a clear.
  always_comb begin
    rise_d     = filt_d & ~filt_q;
    fall_d     = ~filt_d & filt_q;
    irq_pend_d = (irq_pend_q & ~irq_clr_i) | rise_q | fall_q;
  end

  // All state registers, cleared asynchronously.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pad_c2p_q    <= '0;
      pad_c2p_en_q <= '0;
      for (int s = 0; s < SyncStages; s++) begin
        sync_q[s] <= '0;
      end
      filt_q <= '0;
      for (int i = 0; i < NumPads; i++) begin
        cnt_q[i] <= '0;
      end
      rise_q     <= '0;
      fall_q     <= '0;
      irq_pend_q <= '0;
    end else begin
      pad_c2p_q    <= pad_c2p_d;
      pad_c2p_en_q <= pad_c2p_en_d;
      for (int s = 0; s < SyncStages; s++) begin
        sync_q[s] <= sync_d[s];
      end
      filt_q <= filt_d;
      for (int i = 0; i < NumPads; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      rise_q     <= rise_d;
      fall_q     <= fall_d;
      irq_pend_q <= irq_pend_d;
    end
  end

  assign pad_c2p_o    = pad_c2p_q;
  assign pad_c2p_en_o = pad_c2p_en_q;
  assign soc_gpio_i_o = filt_q;
  assign rise_o       = rise_q;
  assign fall_o       = fall_q;
  assign irq_pend_o   = irq_pend_q;
  assign irq_o        = |(irq_pend_q & ~irq_mask_i);

endmodule
